// File: rtl/memory_access_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memory_access_stage_pkg
//  Purpose  : Shared constants, opcodes and pipeline stage-state encoding.
//  Revision : 1.0
// ============================================================================
package memory_access_stage_pkg;

    localparam int          DEFAULT_WORD_LENGTH = 32;
    localparam logic [5:0]  OP_LD               = 6'h23;
    localparam logic [5:0]  OP_ST               = 6'h2B;

    typedef enum logic [1:0] {
        PH0  = 2'd0,
        PH1  = 2'd1,
        WAIT = 2'd2
    } stage_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_stage_dcache_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_req_ctrl
//  Purpose  : Half-cycle FSM, data-cache req/ack handshake, stall and hold regs.
//  Revision : 1.0
// ============================================================================
module dcache_req_ctrl
    import memory_access_stage_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_i,
    input  logic                   we_i,
    input  logic [WORD_LENGTH-1:0] adr_i,
    input  logic [WORD_LENGTH-1:0] wdata_i,
    input  logic                   dack_i,
    output logic                   latch_o,
    output logic                   complete_o,
    output logic                   enter_wait_o,
    output logic                   stall_o,
    output logic                   dreq_o,
    output logic                   dwe_o,
    output logic [WORD_LENGTH-1:0] dadr_o,
    output logic [WORD_LENGTH-1:0] dwdata_o
);

    stage_state_e            state_q, state_d;
    logic                    req_q;
    logic                    we_q;
    logic [WORD_LENGTH-1:0]  adr_q;
    logic [WORD_LENGTH-1:0]  wdata_q;

    // An ack is only meaningful while a request is outstanding.
    always_comb begin
        state_d    = state_q;
        complete_o = 1'b0;
        case (state_q)
            PH0: state_d = PH1;
            PH1: begin
                if (!req_q || dack_i) begin
                    complete_o = 1'b1;
                    state_d    = PH0;
                end else begin
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (dack_i) begin
                    complete_o = 1'b1;
                    state_d    = PH0;
                end
            end
            default: state_d = PH0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PH0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == PH0) begin
                req_q   <= issue_i;
                we_q    <= issue_i & we_i;
                adr_q   <= issue_i ? adr_i   : '0;
                wdata_q <= issue_i ? wdata_i : '0;
            end else if (complete_o) begin
                req_q   <= 1'b0;
                we_q    <= 1'b0;
                adr_q   <= '0;
                wdata_q <= '0;
            end
        end
    end

    assign latch_o      = (state_q == PH0);
    assign stall_o      = (state_q == WAIT);
    assign enter_wait_o = (state_q == PH1) && (state_d == WAIT);
    assign dreq_o       = req_q;
    assign dwe_o        = we_q;
    assign dadr_o       = adr_q;
    assign dwdata_o     = wdata_q;

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : memory_access_stage
//  Purpose  : LD/ST pipeline stage: EA adder, opcode decode, output registers.
//  Revision : 1.0
// ============================================================================
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inValid,
    input  logic [WORD_LENGTH-1:0] inPstate0,
    input  logic [WORD_LENGTH-1:0] inPstate1,
    input  logic [WORD_LENGTH-1:0] inInstr,
    input  logic [WORD_LENGTH-1:0] inValA,
    input  logic [WORD_LENGTH-1:0] inValB,
    input  logic [WORD_LENGTH-1:0] inValX,
    output logic                   outStall,
    output logic                   outValid,
    output logic [WORD_LENGTH-1:0] outPstate0,
    output logic [WORD_LENGTH-1:0] outPstate1,
    output logic [WORD_LENGTH-1:0] outInstr,
    output logic [WORD_LENGTH-1:0] outValA,
    output logic [WORD_LENGTH-1:0] outValB,
    output logic                   outTrap,
    output logic [3:0]             outBypassRegId,
    output logic [WORD_LENGTH-1:0] outBypassRegVal,
    output logic                   dReq,
    output logic                   dWe,
    output logic [WORD_LENGTH-1:0] dAdr,
    output logic [WORD_LENGTH-1:0] dWdata,
    input  logic [WORD_LENGTH-1:0] dRdata,
    input  logic                   dAck
);

    logic [WORD_LENGTH-1:0] w_ea;
    logic [5:0]             w_op;
    logic                   w_mem, w_is_ld, w_misal, w_issue;
    logic                   w_latch, w_complete, w_enter_wait;

    logic                   valid_q, ld_ok_q, trap_q;
    logic [WORD_LENGTH-1:0] pst0_q, pst1_q, instr_q, a_q, ea_q;

    assign w_ea    = inValB + inValX;
    assign w_op    = inInstr[31:26];
    assign w_mem   = inValid && is_mem_op(w_op);
    assign w_is_ld = inValid && (w_op == OP_LD);
    assign w_misal = |w_ea[1:0];
    assign w_issue = w_mem && !w_misal;

    dcache_req_ctrl #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_req_ctrl (
        .clk          (clk),
        .rst          (rst),
        .issue_i      (w_issue),
        .we_i         (w_op == OP_ST),
        .adr_i        (w_ea),
        .wdata_i      (inValA),
        .dack_i       (dAck),
        .latch_o      (w_latch),
        .complete_o   (w_complete),
        .enter_wait_o (w_enter_wait),
        .stall_o      (outStall),
        .dreq_o       (dReq),
        .dwe_o        (dWe),
        .dadr_o       (dAdr),
        .dwdata_o     (dWdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ld_ok_q <= 1'b0;
            trap_q  <= 1'b0;
            pst0_q  <= '0;
            pst1_q  <= '0;
            instr_q <= '0;
            a_q     <= '0;
            ea_q    <= '0;
        end else if (w_latch) begin
            valid_q <= inValid;
            ld_ok_q <= w_is_ld && !w_misal;
            trap_q  <= w_mem && w_misal;
            pst0_q  <= inPstate0;
            pst1_q  <= inPstate1;
            instr_q <= inInstr;
            a_q     <= inValA;
            ea_q    <= w_ea;
        end
    end

    // Entering WAIT shows a bubble downstream until the access completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid        <= 1'b0;
            outPstate0      <= '0;
            outPstate1      <= '0;
            outInstr        <= '0;
            outValA         <= '0;
            outValB         <= '0;
            outTrap         <= 1'b0;
            outBypassRegId  <= '0;
            outBypassRegVal <= '0;
        end else if (w_complete) begin
            outValid        <= valid_q;
            outPstate0      <= pst0_q;
            outPstate1      <= pst1_q;
            outInstr        <= instr_q;
            outValA         <= ld_ok_q ? dRdata : a_q;
            outValB         <= ea_q;
            outTrap         <= trap_q;
            outBypassRegId  <= ld_ok_q ? instr_q[25:22] : 4'd0;
            outBypassRegVal <= ld_ok_q ? dRdata : '0;
        end else if (w_enter_wait) begin
            outValid        <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_access_stage
//  Purpose  : Randomized scoreboard bench for memory_access_stage.
//  Revision : 1.0
// ============================================================================
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [31:0] inPstate0, inPstate1, inInstr, inValA, inValB, inValX;
    logic        outStall, outValid, outTrap;
    logic [31:0] outPstate0, outPstate1, outInstr, outValA, outValB;
    logic [3:0]  outBypassRegId;
    logic [31:0] outBypassRegVal;
    logic        dReq, dWe, dAck;
    logic [31:0] dAdr, dWdata, dRdata;

    memory_access_stage #(.WORD_LENGTH(32)) dut (
        .clk (clk), .rst (rst), .inValid (inValid),
        .inPstate0 (inPstate0), .inPstate1 (inPstate1), .inInstr (inInstr),
        .inValA (inValA), .inValB (inValB), .inValX (inValX),
        .outStall (outStall), .outValid (outValid),
        .outPstate0 (outPstate0), .outPstate1 (outPstate1), .outInstr (outInstr),
        .outValA (outValA), .outValB (outValB), .outTrap (outTrap),
        .outBypassRegId (outBypassRegId), .outBypassRegVal (outBypassRegVal),
        .dReq (dReq), .dWe (dWe), .dAdr (dAdr), .dWdata (dWdata),
        .dRdata (dRdata), .dAck (dAck)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] p0, p1, ins, va, vb;
        logic        trap;
        logic [3:0]  id;
        logic [31:0] bv;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
        end
    endtask

    // Reference: one instruction's architectural result from the stage rules.
    task automatic push_exp(input logic v, input logic [31:0] p0, p1, ins, a, b, x, rd,
                            output bit req, output logic [31:0] ea);
        exp_t e;
        bit   mem, ld;
        ea   = b + x;
        mem  = v && (ins[31:26] == OP_LD || ins[31:26] == OP_ST);
        req  = mem && (ea[1:0] == 2'b00);
        ld   = req && (ins[31:26] == OP_LD);
        e.v    = v;
        e.p0   = p0;
        e.p1   = p1;
        e.ins  = ins;
        e.va   = ld ? rd : a;
        e.vb   = ea;
        e.trap = mem && !req;
        e.id   = ld ? ins[25:22] : 4'd0;
        e.bv   = ld ? rd : 32'd0;
        q.push_back(e);
    endtask

    // Called in a PH0 clock, after the active edge.
    task automatic run_instr(input logic v, input logic [31:0] p0, p1, ins, a, b, x, rd,
                             input int w, input bit stray);
        bit          req;
        logic [31:0] ea;
        push_exp(v, p0, p1, ins, a, b, x, rd, req, ea);
        inValid = v; inPstate0 = p0; inPstate1 = p1; inInstr = ins;
        inValA = a; inValB = b; inValX = x;
        dAck = stray; dRdata = $urandom;
        @(posedge clk); #1;
        inValid = 1'($urandom); inInstr = $urandom; inValA = $urandom;
        inValB = $urandom; inValX = $urandom; inPstate0 = $urandom;
        chk("dReq_ph1", dReq, req);
        if (req) begin
            chk("dWe", dWe, ins[31:26] == OP_ST);
            chk("dAdr", dAdr, ea);
            chk("dWdata", dWdata, a);
            for (int i = 0; i < w; i++) begin
                dAck = 1'b0; dRdata = $urandom;
                @(posedge clk); #1;
                chk("stall_wait", outStall, 1);
                chk("valid_wait", outValid, 0);
                chk("dReq_wait", dReq, 1);
                chk("dAdr_wait", dAdr, ea);
                chk("dWdata_wait", dWdata, a);
            end
            dAck = 1'b1; dRdata = rd;
            @(posedge clk); #1;
            dAck = 1'b0;
            chk("dReq_drop", dReq, 0);
        end else begin
            dAck = stray | 1'($urandom_range(0, 1)); dRdata = $urandom;
            @(posedge clk); #1;
            dAck = 1'b0;
        end
    endtask

    // Monitor: tracks pipeline phase from the handshake and checks each completion.
    int   m_ph;
    logic p_req, p_ack;
    always @(negedge clk) begin : monitor
        bit   done;
        exp_t e;
        if (rst) begin
            m_ph = 0; p_req = 1'b0; p_ack = 1'b0;
            q.delete();
        end else begin
            done = 1'b0;
            case (m_ph)
                0: m_ph = 1;
                1: if (!p_req || p_ack) begin done = 1'b1; m_ph = 0; end else m_ph = 2;
                default: if (p_ack) begin done = 1'b1; m_ph = 0; end
            endcase
            p_req = dReq;
            p_ack = dAck;
            chk("stall_phase", outStall, m_ph == 2);
            if (done) begin
                chk("queue_has_entry", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("outValid", outValid, e.v);
                    chk("outPstate0", outPstate0, e.p0);
                    chk("outPstate1", outPstate1, e.p1);
                    chk("outInstr", outInstr, e.ins);
                    chk("outValA", outValA, e.va);
                    chk("outValB", outValB, e.vb);
                    chk("outTrap", outTrap, e.trap);
                    chk("bypassId", outBypassRegId, e.id);
                    chk("bypassVal", outBypassRegVal, e.bv);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit          req;
        logic [31:0] ea, ins, b;
        logic [5:0]  op;
        rst = 1'b1; inValid = 0; inPstate0 = 0; inPstate1 = 0; inInstr = 0;
        inValA = 0; inValB = 0; inValX = 0; dAck = 0; dRdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outValid", outValid, 0);
        chk("rst_outStall", outStall, 0);
        chk("rst_outTrap", outTrap, 0);
        chk("rst_dReq", dReq, 0);
        chk("rst_dWe", dWe, 0);
        chk("rst_dAdr", dAdr, 0);
        chk("rst_dWdata", dWdata, 0);
        chk("rst_outValA", outValA, 0);
        chk("rst_outValB", outValB, 0);
        chk("rst_bypassId", outBypassRegId, 0);
        chk("rst_bypassVal", outBypassRegVal, 0);
        chk("rst_outInstr", outInstr, 0);
        @(negedge clk); #1;
        rst = 1'b0;

        run_instr(1, 32'h1, 32'h2, {6'h01, 26'h0}, 32'h11, 32'h10, 32'h4, 32'h0, 0, 0);
        run_instr(1, 32'h3, 32'h4, {OP_LD, 4'd5, 22'h0}, 32'h77, 32'h1000, 32'h8, 32'hCAFEF00D, 0, 0);
        run_instr(1, 32'h5, 32'h6, {OP_ST, 4'd3, 22'h1}, 32'hA5A5A5A5, 32'h2000, 32'h0, 32'hDEAD0000, 3, 0);
        run_instr(1, 32'h7, 32'h8, {OP_LD, 4'd6, 22'h0}, 32'h99, 32'h1001, 32'h0, 32'h11112222, 2, 0);
        run_instr(1, 32'h9, 32'hA, {OP_LD, 4'd7, 22'h0}, 32'h55, 32'hFFFFFFFC, 32'h8, 32'h12345678, 1, 0);
        run_instr(0, 32'hB, 32'hC, {OP_LD, 4'd2, 22'h0}, 32'h44, 32'h100, 32'h0, 32'h0BADF00D, 0, 0);

        // Reset while an ST sits in WAIT.
        push_exp(1, 32'hD, 32'hE, {OP_ST, 4'd1, 22'h0}, 32'h5A5A5A5A, 32'h3000, 32'h4, 32'h0, req, ea);
        inValid = 1; inPstate0 = 32'hD; inPstate1 = 32'hE; inInstr = {OP_ST, 4'd1, 22'h0};
        inValA = 32'h5A5A5A5A; inValB = 32'h3000; inValX = 32'h4; dAck = 0;
        @(posedge clk); #1;
        chk("rstw_dReq_ph1", dReq, 1);
        @(posedge clk); #1;
        chk("rstw_stall", outStall, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_dReq", dReq, 0);
        chk("rstw_dWe", dWe, 0);
        chk("rstw_dAdr", dAdr, 0);
        chk("rstw_stall0", outStall, 0);
        chk("rstw_outValA", outValA, 0);
        chk("rstw_outValB", outValB, 0);
        chk("rstw_bypassId", outBypassRegId, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        run_instr(0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_LD;
                1:       op = OP_ST;
                default: op = 6'($urandom);
            endcase
            ins = {op, 26'($urandom)};
            b   = $urandom;
            if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
            run_instr(($urandom_range(0, 9) != 0), $urandom, $urandom, ins, $urandom, b,
                      ($urandom_range(0, 3) != 0) ? {$urandom} & 32'hFFFFFFFC : $urandom,
                      $urandom, $urandom_range(0, 3), 0);
        end

        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
